// File: rtl/ahb_rdata_resp_mux.sv
// ahb_rdata_resp_mux
//   AHB slave-to-master response multiplexer with a registered data-phase select
//   and a built-in default slave. The decoder select is captured in the address
//   phase. During the data phase the selected slave's HRDATA/HREADYOUT/HRESP is
//   routed to the master. An active transfer that hits no slave gets the
//   two-cycle ERROR response, and each such decode error is counted.
//
// Ports
//   hclk, hreset  clock; asynchronous active-high reset
//   hsel_vec      decoder select, address phase (lowest set bit wins)
//   htrans        master HTRANS, address phase (only bit 1 is used)
//   hrdata_s      packed slave read data, slave i at [i*DATA_W +: DATA_W]
//   hreadyout_s   slave HREADYOUT
//   hresp_s       slave HRESP (1 = ERROR)
//   hrdata        read data to master
//   hready        HREADY to master and all slaves
//   hresp         HRESP to master
//   err_count     saturating count of decode errors

module ahb_rdata_resp_mux #(
    parameter int unsigned NUM_SLAVES = 4,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned CNT_W      = 8
) (
    input  logic                         hclk,
    input  logic                         hreset,
    input  logic [NUM_SLAVES-1:0]        hsel_vec,
    input  logic [1:0]                   htrans,
    input  logic [NUM_SLAVES*DATA_W-1:0] hrdata_s,
    input  logic [NUM_SLAVES-1:0]        hreadyout_s,
    input  logic [NUM_SLAVES-1:0]        hresp_s,
    output logic [DATA_W-1:0]            hrdata,
    output logic                         hready,
    output logic                         hresp,
    output logic [CNT_W-1:0]             err_count
);

    localparam int unsigned SEL_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

    typedef enum logic [1:0] {StIdle, StErr1, StErr2} state_e;

    state_e             state_q, state_d;
    logic               dp_valid_q, dp_valid_d;
    logic [SEL_W-1:0]   dp_sel_q, dp_sel_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   sel_lo;
    logic               def_hit;
    logic               capture;

    // HTRANS[0] only distinguishes IDLE/BUSY and NONSEQ/SEQ, which do not matter here.
    logic unused_htrans0;
    assign unused_htrans0 = htrans[0];

    // Unpacked view of the slave data bus for clean indexing.
    logic [DATA_W-1:0] slv_data [NUM_SLAVES];
    for (genvar g = 0; g < NUM_SLAVES; g++) begin : g_slice
        assign slv_data[g] = hrdata_s[g*DATA_W +: DATA_W];
    end

    // Lowest index wins: scan downward so the last hit is the lowest set bit.
    always_comb begin
        sel_lo = '0;
        for (int i = NUM_SLAVES - 1; i >= 0; i--) begin
            if (hsel_vec[i]) sel_lo = SEL_W'(i);
        end
    end

    assign capture = hready;
    assign def_hit = htrans[1] & ~(|hsel_vec);

    always_comb begin
        state_d    = state_q;
        dp_valid_d = dp_valid_q;
        dp_sel_d   = dp_sel_q;
        cnt_d      = cnt_q;

        if (capture) begin
            dp_sel_d   = sel_lo;
            dp_valid_d = htrans[1] & (|hsel_vec);
        end

        case (state_q)
            StIdle:  if (capture && def_hit) state_d = StErr1;
            StErr1:  state_d = StErr2;
            StErr2:  state_d = (capture && def_hit) ? StErr1 : StIdle;
            default: state_d = StIdle;
        endcase

        if (state_q == StErr1) dp_valid_d = 1'b0;

        // Count every entry into ERR1, including ERR2->ERR1 chaining.
        if (state_d == StErr1 && state_q != StErr1 && cnt_q != {CNT_W{1'b1}}) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge hclk or posedge hreset) begin
        if (hreset) begin
            state_q    <= StIdle;
            dp_valid_q <= 1'b0;
            dp_sel_q   <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            dp_valid_q <= dp_valid_d;
            dp_sel_q   <= dp_sel_d;
            cnt_q      <= cnt_d;
        end
    end

    // Default-slave states take precedence; they never coexist with a valid data phase.
    always_comb begin
        hrdata = '0;
        hready = 1'b1;
        hresp  = 1'b0;
        if (state_q == StErr1) begin
            hready = 1'b0;
            hresp  = 1'b1;
        end else if (state_q == StErr2) begin
            hready = 1'b1;
            hresp  = 1'b1;
        end else if (dp_valid_q) begin
            hrdata = slv_data[dp_sel_q];
            hready = hreadyout_s[dp_sel_q];
            hresp  = hresp_s[dp_sel_q];
        end
    end

    assign err_count = cnt_q;

endmodule

// File: tb/tb_ahb_rdata_resp_mux.sv
module tb_ahb_rdata_resp_mux;

    localparam int unsigned NS = 4;
    localparam int unsigned DW = 32;
    localparam int unsigned CW = 2;

    logic             hclk;
    logic             hreset;
    logic [NS-1:0]    hsel_vec;
    logic [1:0]       htrans;
    logic [NS*DW-1:0] hrdata_s;
    logic [NS-1:0]    hreadyout_s;
    logic [NS-1:0]    hresp_s;
    logic [DW-1:0]    hrdata;
    logic             hready;
    logic             hresp;
    logic [CW-1:0]    err_count;

    int n_vec;
    int n_bad;

    ahb_rdata_resp_mux #(
        .NUM_SLAVES(NS),
        .DATA_W    (DW),
        .CNT_W     (CW)
    ) dut (
        .hclk       (hclk),
        .hreset     (hreset),
        .hsel_vec   (hsel_vec),
        .htrans     (htrans),
        .hrdata_s   (hrdata_s),
        .hreadyout_s(hreadyout_s),
        .hresp_s    (hresp_s),
        .hrdata     (hrdata),
        .hready     (hready),
        .hresp      (hresp),
        .err_count  (err_count)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    typedef struct {
        logic [3:0]  hsel;
        logic [1:0]  trans;
        logic [3:0]  rdy;
        logic [3:0]  rsp;
        logic [31:0] e_rdata;
        logic        e_ready;
        logic        e_resp;
        logic [1:0]  e_cnt;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic [3:0] hs, input logic [1:0] tr, input logic [3:0] rd,
                       input logic [3:0] rs, input logic [31:0] erd, input logic erdy,
                       input logic ersp, input logic [1:0] ecnt);
        vec_t v;
        v.hsel = hs; v.trans = tr; v.rdy = rd; v.rsp = rs;
        v.e_rdata = erd; v.e_ready = erdy; v.e_resp = ersp; v.e_cnt = ecnt;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic chk_out(input string name, input logic [31:0] erd, input logic erdy,
                           input logic ersp, input logic [1:0] ecnt);
        chk({name, ".hrdata"}, hrdata, erd);
        chk({name, ".hready"}, {31'd0, hready}, {31'd0, erdy});
        chk({name, ".hresp"}, {31'd0, hresp}, {31'd0, ersp});
        chk({name, ".err_count"}, {30'd0, err_count}, {30'd0, ecnt});
    endtask

    task automatic drive(input logic [3:0] hs, input logic [1:0] tr, input logic [3:0] rd,
                         input logic [3:0] rs);
        hsel_vec = hs; htrans = tr; hreadyout_s = rd; hresp_s = rs;
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are sampled 1 unit later.
    task automatic tick();
        @(posedge hclk);
        #1;
    endtask

    localparam logic [1:0] TIdle = 2'b00;
    localparam logic [1:0] TNseq = 2'b10;
    localparam logic [1:0] TSeq  = 2'b11;
    localparam logic [31:0] D0 = 32'hCAFE0000;
    localparam logic [31:0] D1 = 32'hCAFE0001;
    localparam logic [31:0] D2 = 32'hCAFE0002;
    localparam logic [31:0] D3 = 32'hCAFE0003;

    initial begin
        n_vec = 0;
        n_bad = 0;
        hrdata_s = {D3, D2, D1, D0};
        drive(4'b0000, TIdle, 4'b1111, 4'b0000);

        //   hsel     trans  rdy      rsp      rdata exp rdy rsp cnt
        // Routing to slave 2
        add(4'b0100, TNseq, 4'b1111, 4'b0000, 32'd0, 1'b1, 1'b0, 2'd0);
        add(4'b0000, TIdle, 4'b1111, 4'b0000, D2,    1'b1, 1'b0, 2'd0);
        // Slave ERROR passes through without counting
        add(4'b0010, TNseq, 4'b1111, 4'b0000, 32'd0, 1'b1, 1'b0, 2'd0);
        add(4'b0000, TIdle, 4'b1111, 4'b0010, D1,    1'b1, 1'b1, 2'd0);
        // Wait states on slave 1 while the decoder already points at slave 3
        add(4'b0010, TNseq, 4'b1111, 4'b0000, 32'd0, 1'b1, 1'b0, 2'd0);
        add(4'b1000, TNseq, 4'b1101, 4'b0000, D1,    1'b0, 1'b0, 2'd0);
        add(4'b1000, TNseq, 4'b1101, 4'b0000, D1,    1'b0, 1'b0, 2'd0);
        add(4'b1000, TNseq, 4'b1111, 4'b0000, D1,    1'b1, 1'b0, 2'd0);
        add(4'b0000, TIdle, 4'b1111, 4'b0000, D3,    1'b1, 1'b0, 2'd0);
        // Decode error; select during ERR1 must be ignored
        add(4'b0000, TNseq, 4'b1111, 4'b0000, 32'd0, 1'b1, 1'b0, 2'd0);
        add(4'b0001, TNseq, 4'b1111, 4'b0000, 32'd0, 1'b0, 1'b1, 2'd1);
        add(4'b0000, TIdle, 4'b1111, 4'b0000, 32'd0, 1'b1, 1'b1, 2'd1);
        add(4'b0000, TIdle, 4'b1111, 4'b0000, 32'd0, 1'b1, 1'b0, 2'd1);
        // Back-to-back slave 0 then slave 3, then priority on 0110
        add(4'b0001, TNseq, 4'b1111, 4'b0000, 32'd0, 1'b1, 1'b0, 2'd1);
        add(4'b1000, TSeq,  4'b1111, 4'b0000, D0,    1'b1, 1'b0, 2'd1);
        add(4'b0110, TNseq, 4'b1111, 4'b0000, D3,    1'b1, 1'b0, 2'd1);
        add(4'b0000, TIdle, 4'b1111, 4'b0000, D1,    1'b1, 1'b0, 2'd1);
        // Chained decode errors up to saturation
        add(4'b0000, TNseq, 4'b1111, 4'b0000, 32'd0, 1'b1, 1'b0, 2'd1);
        add(4'b0000, TNseq, 4'b1111, 4'b0000, 32'd0, 1'b0, 1'b1, 2'd2);
        add(4'b0000, TNseq, 4'b1111, 4'b0000, 32'd0, 1'b1, 1'b1, 2'd2);
        add(4'b0000, TNseq, 4'b1111, 4'b0000, 32'd0, 1'b0, 1'b1, 2'd3);
        add(4'b0000, TNseq, 4'b1111, 4'b0000, 32'd0, 1'b1, 1'b1, 2'd3);
        add(4'b0000, TIdle, 4'b1111, 4'b0000, 32'd0, 1'b0, 1'b1, 2'd3);
        add(4'b0000, TIdle, 4'b1111, 4'b0000, 32'd0, 1'b1, 1'b1, 2'd3);
        add(4'b0000, TIdle, 4'b1111, 4'b0000, 32'd0, 1'b1, 1'b0, 2'd3);

        // Reset state
        hreset = 1'b1;
        #1;
        chk_out("reset", 32'd0, 1'b1, 1'b0, 2'd0);
        tick();
        hreset = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].hsel, vecs[i].trans, vecs[i].rdy, vecs[i].rsp);
            #1;
            chk_out($sformatf("vec%0d", i), vecs[i].e_rdata, vecs[i].e_ready,
                    vecs[i].e_resp, vecs[i].e_cnt);
            tick();
        end

        // Five chained decode errors from a fresh reset: no IDLE gap between them
        hreset = 1'b1;
        #1;
        hreset = 1'b0;
        drive(4'b0000, TNseq, 4'b1111, 4'b0000);
        for (int k = 0; k < 5; k++) begin
            #1;
            chk($sformatf("chain%0d.accept_ready", k), {31'd0, hready}, 32'd1);
            chk($sformatf("chain%0d.accept_resp", k), {31'd0, hresp}, (k == 0) ? 32'd0 : 32'd1);
            tick();
            chk($sformatf("chain%0d.err1_ready", k), {31'd0, hready}, 32'd0);
            chk($sformatf("chain%0d.err1_resp", k), {31'd0, hresp}, 32'd1);
            chk($sformatf("chain%0d.cnt", k), {30'd0, err_count}, (k >= 2) ? 32'd3 : k + 1);
            tick();
        end
        drive(4'b0000, TIdle, 4'b1111, 4'b0000);
        tick();

        // Async reset while in ERR1 takes effect without a clock edge
        drive(4'b0000, TNseq, 4'b1111, 4'b0000);
        tick();
        #1;
        chk("err1_pre_reset.hready", {31'd0, hready}, 32'd0);
        hreset = 1'b1;
        #1;
        chk_out("err1_async_reset", 32'd0, 1'b1, 1'b0, 2'd0);
        tick();
        hreset = 1'b0;

        // Async reset in the middle of a routed data phase
        drive(4'b0100, TNseq, 4'b1111, 4'b0000);
        tick();
        drive(4'b0000, TIdle, 4'b1011, 4'b0100);
        #1;
        chk_out("dp_pre_reset", D2, 1'b0, 1'b1, 2'd0);
        hreset = 1'b1;
        #1;
        chk_out("dp_async_reset", 32'd0, 1'b1, 1'b0, 2'd0);
        tick();
        hreset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
